digit_serial_subtractor: RTL and testbench

- Multi-cycle unsigned subtractor. Computes A - B over N bits, W bits per clock, and keeps the borrow in a register between chunks.
- It is the subtract-direction counterpart to the team's N-bit ripple adders. It trades latency for a W-bit-wide datapath.
- Operands enter on a valid/ready start handshake. Results leave on a valid/ready done handshake.
- Intended for area-constrained datapaths where operand width exceeds the per-cycle logic budget.

---
 rtl/digit_serial_subtractor_if.sv | 35 +++
 rtl/digit_serial_subtractor.sv | 129 ++++++++++++
 tb/tb_digit_serial_subtractor.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/digit_serial_subtractor_if.sv
// Start/done handshake bundle for digit_serial_subtractor; carries ovf when SIGNED_OVF_EN is defined.
// The master side is the operand producer and result consumer; the slave side is the subtractor.
interface digit_serial_subtractor_if #(
    parameter int N = 8
);
    logic         start_valid;
    logic         start_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] diff;
    logic         bout;
    logic         done_valid;
    logic         done_ready;
`ifdef SIGNED_OVF_EN
    logic         ovf;

    modport master (
        output start_valid, A, B, done_ready,
        input  start_ready, diff, bout, done_valid, ovf
    );
    modport slave (
        input  start_valid, A, B, done_ready,
        output start_ready, diff, bout, done_valid, ovf
    );
`else
    modport master (
        output start_valid, A, B, done_ready,
        input  start_ready, diff, bout, done_valid
    );
    modport slave (
        input  start_valid, A, B, done_ready,
        output start_ready, diff, bout, done_valid
    );
`endif
endinterface

// File: rtl/digit_serial_subtractor.sv
// Purpose: unsigned A - B over N bits, W bits per cycle, borrow carried in a register (SIGNED_OVF_EN adds ovf).
// Latency: N/W cycles from start acceptance to done_valid; minimum initiation interval N/W+2.
// Backpressure: result held stable in DONE while done_ready is low; start_ready is high only in IDLE.
module digit_serial_subtractor #(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    digit_serial_subtractor_if.slave  bus
);
    localparam int C  = N / W;
    localparam int CW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          borrow_q;
    logic [N-1:0]  a_q, b_q, diff_q;
    logic          bout_q;
    logic [W-1:0]  a_k, b_k, d;
    logic [W:0]    sub;
    logic          b_next;
    logic          last;
    logic          start_ready;
    logic          done_valid;
    logic          accept;
`ifdef SIGNED_OVF_EN
    logic          ovf_q;
`endif

    // Chunk select by comparison so no index can ever reach past chunk C-1.
    always_comb begin
        a_k = '0;
        b_k = '0;
        for (int j = 0; j < C; j++) begin
            if (cnt_q == CW'(j)) begin
                a_k = a_q[j*W +: W];
                b_k = b_q[j*W +: W];
            end
        end
        sub    = {1'b0, a_k} - {1'b0, b_k} - {{W{1'b0}}, borrow_q};
        d      = sub[W-1:0];
        b_next = sub[W];
        last   = (cnt_q == CW'(C - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (bus.start_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_valid = 1'b1;
                if (bus.done_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
`ifdef SIGNED_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else if (accept) begin
            a_q      <= bus.A;
            b_q      <= bus.B;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else if (state_q == RUN) begin
            for (int j = 0; j < C; j++) begin
                if (cnt_q == CW'(j)) begin
                    diff_q[j*W +: W] <= d;
                end
            end
            borrow_q <= b_next;
            if (last) begin
                bout_q <= b_next;
                cnt_q  <= '0;
`ifdef SIGNED_OVF_EN
                // d[W-1] is the final result MSB, written this same edge.
                ovf_q  <= (a_q[N-1] != b_q[N-1]) & (d[W-1] != a_q[N-1]);
`endif
            end else begin
                cnt_q  <= cnt_q + CW'(1);
            end
        end
    end

    assign bus.start_ready = start_ready;
    assign bus.done_valid  = done_valid;
    assign bus.diff        = diff_q;
    assign bus.bout        = bout_q;
`ifdef SIGNED_OVF_EN
    assign bus.ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Directed bench for digit_serial_subtractor with W=2 (main), W=1 and W=8 instances; checks ovf when SIGNED_OVF_EN is defined.
module tb_digit_serial_subtractor;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    digit_serial_subtractor_if #(.N(N)) bus2 ();
    digit_serial_subtractor_if #(.N(N)) bus1 ();
    digit_serial_subtractor_if #(.N(N)) bus8 ();

    digit_serial_subtractor #(.N(N), .W(2)) u_dut    (.clk(clk), .rst(rst), .bus(bus2));
    digit_serial_subtractor #(.N(N), .W(1)) u_dut_w1 (.clk(clk), .rst(rst), .bus(bus1));
    digit_serial_subtractor #(.N(N), .W(8)) u_dut_w8 (.clk(clk), .rst(rst), .bus(bus8));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic sv, input logic [7:0] a, input logic [7:0] b, input logic dr);
        case (sel)
            1: begin bus1.start_valid = sv; bus1.A = a; bus1.B = b; bus1.done_ready = dr; end
            8: begin bus8.start_valid = sv; bus8.A = a; bus8.B = b; bus8.done_ready = dr; end
            default: begin bus2.start_valid = sv; bus2.A = a; bus2.B = b; bus2.done_ready = dr; end
        endcase
    endtask

    // {ovf, bout, done_valid, start_ready, diff[7:0]}
    function automatic logic [11:0] obs(input int sel);
        logic [11:0] o;
        case (sel)
            1:       o = {1'b0, bus1.bout, bus1.done_valid, bus1.start_ready, bus1.diff};
            8:       o = {1'b0, bus8.bout, bus8.done_valid, bus8.start_ready, bus8.diff};
            default: o = {1'b0, bus2.bout, bus2.done_valid, bus2.start_ready, bus2.diff};
        endcase
`ifdef SIGNED_OVF_EN
        case (sel)
            1:       o[11] = bus1.ovf;
            8:       o[11] = bus8.ovf;
            default: o[11] = bus2.ovf;
        endcase
`endif
        return o;
    endfunction

    // One full transaction; hold = cycles done_ready stays low with operands toggling.
    task automatic do_op(input int sel, input int w, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ed, input logic eb, input logic eo, input int hold, input string tag);
        int cyc;
        logic [11:0] o;
        cyc = 0;
        o = obs(sel);
        while (!o[8] && cyc < 20) begin tick(); cyc++; o = obs(sel); end
        check({tag, ".start_ready"}, 32'(o[8]), 32'd1);
        drive(sel, 1'b1, a, b, 1'b0);
        tick();
        drive(sel, 1'b0, ~a, ~b, 1'b0);
        cyc = 0;
        o = obs(sel);
        while (!o[9] && cyc < 40) begin tick(); cyc++; o = obs(sel); end
        check({tag, ".latency"}, 32'(cyc), 32'(N / w));
        check({tag, ".diff"}, 32'(o[7:0]), 32'(ed));
        check({tag, ".bout"}, 32'(o[10]), 32'(eb));
`ifdef SIGNED_OVF_EN
        check({tag, ".ovf"}, 32'(o[11]), 32'(eo));
`else
        if (eo) cyc = cyc + 0;
`endif
        for (int h = 0; h < hold; h++) begin
            drive(sel, 1'b0, 8'($urandom), 8'($urandom), 1'b0);
            tick();
            o = obs(sel);
            check({tag, ".hold.diff"}, 32'(o[7:0]), 32'(ed));
            check({tag, ".hold.bout"}, 32'(o[10]), 32'(eb));
            check({tag, ".hold.done_valid"}, 32'(o[9]), 32'd1);
            check({tag, ".hold.start_ready"}, 32'(o[8]), 32'd0);
        end
        drive(sel, 1'b0, a ^ 8'h55, b, 1'b1);
        tick();
        drive(sel, 1'b0, 8'h00, 8'h00, 1'b0);
        o = obs(sel);
        check({tag, ".done_valid_fall"}, 32'(o[9]), 32'd0);
        check({tag, ".start_ready_back"}, 32'(o[8]), 32'd1);
    endtask

    logic [7:0] sa [3] = '{8'h9C, 8'h01, 8'h80};
    logic [7:0] sb [3] = '{8'h2D, 8'hFE, 8'h80};
    logic [7:0] sd [3] = '{8'h6F, 8'h03, 8'h00};
    logic       sbo[3] = '{1'b0, 1'b1, 1'b0};

    initial begin
        logic [11:0] o;
        int i;
        int r;
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(2, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        o = obs(2);
        check("reset.start_ready", 32'(o[8]), 32'd1);
        check("reset.done_valid", 32'(o[9]), 32'd0);
        check("reset.diff", 32'(o[7:0]), 32'h00);
        check("reset.bout", 32'(o[10]), 32'd0);

        do_op(2, 2, 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, 0, "basic");
        do_op(2, 2, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 0, "under");
        do_op(2, 2, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 0, "ripple");
        do_op(2, 2, 8'hC3, 8'h41, 8'h82, 1'b0, 1'b0, 5, "bp");
        do_op(2, 2, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0, "ovf1");
        do_op(2, 2, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0, "ovf0");

        // Continuous start_valid with a three-pair stream.
        i = 1;
        r = 0;
        drive(2, 1'b1, sa[0], sb[0], 1'b1);
        for (int c = 0; c < 60 && r < 3; c++) begin
            tick();
            o = obs(2);
            if (o[9]) begin
                check("stream.diff", 32'(o[7:0]), 32'(sd[r]));
                check("stream.bout", 32'(o[10]), 32'(sbo[r]));
                r++;
            end
            if (o[8]) begin
                if (i < 3) begin
                    drive(2, 1'b1, sa[i], sb[i], 1'b1);
                    i++;
                end else begin
                    drive(2, 1'b0, 8'h00, 8'h00, 1'b1);
                end
            end else begin
                drive(2, 1'b1, 8'($urandom), 8'($urandom), 1'b1);
            end
        end
        drive(2, 1'b0, 8'h00, 8'h00, 1'b1);
        check("stream.count", 32'(r), 32'd3);
        for (int c = 0; c < 8; c++) begin
            tick();
            o = obs(2);
            check("stream.no_extra", 32'(o[9]), 32'd0);
        end
        drive(2, 1'b0, 8'h00, 8'h00, 1'b0);

        // Reset during the second RUN cycle.
        drive(2, 1'b1, 8'hFF, 8'h01, 1'b0);
        tick();
        drive(2, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        o = obs(2);
        check("midrst.start_ready", 32'(o[8]), 32'd1);
        check("midrst.done_valid", 32'(o[9]), 32'd0);
        check("midrst.diff", 32'(o[7:0]), 32'h00);
        check("midrst.bout", 32'(o[10]), 32'd0);
`ifdef SIGNED_OVF_EN
        check("midrst.ovf", 32'(o[11]), 32'd0);
`endif
        do_op(2, 2, 8'h07, 8'h03, 8'h04, 1'b0, 1'b0, 0, "afterrst");

        do_op(1, 1, 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, 0, "w1");
        do_op(1, 1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0, "w1ovf");
        do_op(8, 8, 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, 0, "w8");
        do_op(8, 8, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 0, "w8under");
        do_op(8, 8, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0, "w8ovf");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
